// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the WISC-SP22 fetch stage and the control decoder.
//   fetch_state_t : fetch sequencer states
//   OPC_HI/OPC_LO : opcode field position inside an instruction word
//   OPC_HALT      : opcode that stops fetch once delivered
//   NOP_INSTR     : word presented on instr while nothing has been fetched
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam int          OPC_HI    = 15;
    localparam int          OPC_LO    = 11;
    localparam logic [4:0]  OPC_HALT  = 5'b00000;
    localparam logic [15:0] NOP_INSTR = 16'h0800;

    function automatic logic is_halt(input logic [15:0] word);
        return word[OPC_HI:OPC_LO] == OPC_HALT;
    endfunction

endpackage

// File: rtl/instr_fetch_pc.sv
// Program counter for the fetch stage.
//   clk, rst_n : clock, asynchronous active-low reset (pc returns to RESET_PC)
//   advance    : step pc by 2 (a word was captured)
//   load       : take load_pc (redirect); wins over advance
//   load_pc    : redirect target
//   pc         : address currently being fetched
//   pc_plus2   : pc + 2, modulo 2^16
module fetch_pc #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic        load,
    input  logic [15:0] load_pc,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2
);

    // Plain 16-bit add: 16'hFFFE wraps to 16'h0000 by truncation.
    assign pc_plus2 = pc + 16'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (advance) begin
            pc <= pc_plus2;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, requests words from imem, holds each
// fetched word in a one-entry buffer until decode accepts it, applies
// downstream redirects and stops for good once a HALT has been delivered.
//   clk, rst_n    : clock, asynchronous active-low reset
//   imem_req/addr : level request and address to instruction memory
//   imem_rdata/done : returned word and its one-cycle completion pulse
//   redirect, redirect_pc : taken branch/jump and its target
//   stall         : decode cannot take instr this cycle
//   instr, pc_plus2, instr_valid : buffered word, its address + 2, live flag
//   halted, err   : HALT delivered; sticky odd-redirect error
//   dbg_state     : current sequencer state, for observation only
//
// Handshakes: the imem request is pending while imem_req is high and completes
// on the cycle imem_done is high; dropping imem_req abandons it. The buffered
// word transfers to decode on any cycle with instr_valid high and stall low.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req,
    output logic [15:0]  imem_addr,
    input  logic [15:0]  imem_rdata,
    input  logic         imem_done,
    input  logic         redirect,
    input  logic [15:0]  redirect_pc,
    input  logic         stall,
    output logic [15:0]  instr,
    output logic [15:0]  pc_plus2,
    output logic         instr_valid,
    output logic         halted,
    output logic         err,
    output fetch_state_t dbg_state
);

    fetch_state_t state, state_n;
    logic [15:0]  pc, pc_next;
    logic         redir_act, redir_ok, redir_bad;
    logic         capture, accept;

    // Redirects only matter while the stage is live; IDLE and HALTED ignore them.
    assign redir_act = redirect && (state == FETCH || state == HOLD);
    assign redir_ok  = redir_act && !redirect_pc[0];
    assign redir_bad = redir_act &&  redirect_pc[0];
    // A redirect discards both a completing response and a held word.
    assign capture   = (state == FETCH) && imem_done && !redir_act;
    assign accept    = (state == HOLD) && !stall && !redir_act;

    fetch_pc #(.RESET_PC(RESET_PC)) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (capture),
        .load     (redir_ok),
        .load_pc  (redirect_pc),
        .pc       (pc),
        .pc_plus2 (pc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:   state_n = FETCH;
            FETCH: begin
                if (redir_bad)     state_n = HALTED;
                else if (redir_ok) state_n = FETCH;
                else if (capture)  state_n = HOLD;
            end
            HOLD: begin
                if (redir_bad)     state_n = HALTED;
                else if (redir_ok) state_n = FETCH;
                else if (accept)   state_n = is_halt(instr) ? HALTED : FETCH;
            end
            HALTED: state_n = HALTED;
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs come from the registered state alone.
    always_comb begin
        imem_req    = (state == FETCH);
        instr_valid = (state == HOLD);
        halted      = (state == HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= NOP_INSTR;
            pc_plus2 <= 16'h0000;
            err      <= 1'b0;
        end else begin
            if (capture) begin
                instr    <= imem_rdata;
                pc_plus2 <= pc_next;
            end
            if (redir_bad) begin
                err <= 1'b1;
            end
        end
    end

    assign imem_addr = pc;
    assign dbg_state = state;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// episodes, all checked against a transaction-level model of the fetch stream.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         imem_req;
    logic [15:0]  imem_addr;
    logic [15:0]  imem_rdata = 16'h0;
    logic         imem_done = 1'b0;
    logic         redirect = 1'b0;
    logic [15:0]  redirect_pc = 16'h0;
    logic         stall = 1'b0;
    logic [15:0]  instr;
    logic [15:0]  pc_plus2;
    logic         instr_valid;
    logic         halted;
    logic         err;
    fetch_state_t dbg_state;

    instr_fetch #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_done   (imem_done),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .instr       (instr),
        .pc_plus2    (pc_plus2),
        .instr_valid (instr_valid),
        .halted      (halted),
        .err         (err),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- memory image and reference model ----------------
    // Word at address a lives in mem[a[6:1]].
    logic [15:0] mem [64];
    logic [15:0] exp_pc;     // address of the next word in program order
    logic        exp_hold;   // a fetched word is waiting for decode
    logic        exp_halt;
    logic        exp_err;
    int          acc_cnt;
    int          cnt, cur_lat, lat_min, lat_max;
    int          stall_pct, redir_pct;

    task automatic model_reset();
        exp_pc   = 16'h0000;
        exp_hold = 1'b0;
        exp_halt = 1'b0;
        exp_err  = 1'b0;
        acc_cnt  = 0;
        cnt      = 0;
        cur_lat  = $urandom_range(lat_max, lat_min);
    endtask

    task automatic fill_mem_random();
        logic [15:0] w;
        for (int i = 0; i < 64; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 19) == 0) w[15:11] = OPC_HALT;
            else if (w[15:11] == OPC_HALT)  w[15] = 1'b1;
            mem[i] = w;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        imem_done = 1'b0;
        redirect = 1'b0;
        stall = 1'b0;
        redirect_pc = 16'h0;
        @(negedge clk);
        check_eq("rst_req",    {15'h0, imem_req},    16'h0);
        check_eq("rst_addr",   imem_addr,            16'h0000);
        check_eq("rst_instr",  instr,                NOP_INSTR);
        check_eq("rst_pcp2",   pc_plus2,             16'h0000);
        check_eq("rst_valid",  {15'h0, instr_valid}, 16'h0);
        check_eq("rst_halted", {15'h0, halted},      16'h0);
        check_eq("rst_err",    {15'h0, err},         16'h0);
        rst_n = 1'b1;
        model_reset();
        // The IDLE cycle precedes the first request.
        check_eq("idle_req", {15'h0, imem_req}, 16'h0);
    endtask

    // One clock cycle: check current outputs against the model, choose
    // inputs for the coming edge, and advance the model accordingly.
    task automatic drive_cycle(input logic f_stall, input logic f_redir, input logic [15:0] f_pc);
        logic        done_n, stall_n, redir_n, eff;
        logic [15:0] rpc, word;
        @(negedge clk);
        check_eq("halted", {15'h0, halted},      {15'h0, exp_halt});
        check_eq("err",    {15'h0, err},         {15'h0, exp_err});
        check_eq("valid",  {15'h0, instr_valid}, {15'h0, exp_hold});
        check_eq("req",    {15'h0, imem_req},    {15'h0, !exp_halt && !exp_hold});
        if (imem_req) check_eq("addr", imem_addr, exp_pc);

        done_n  = imem_req && (cnt >= cur_lat);
        stall_n = f_stall || ($urandom_range(0, 99) < stall_pct);
        redir_n = f_redir || ($urandom_range(0, 99) < redir_pct);
        if (f_redir) rpc = f_pc;
        else begin
            rpc = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 7) == 0) rpc[0] = 1'b1;
        end
        imem_done   = done_n;
        imem_rdata  = done_n ? mem[imem_addr[6:1]] : 16'($urandom);
        stall       = stall_n;
        redirect    = redir_n;
        redirect_pc = rpc;

        eff = redir_n && !exp_halt;
        if (eff) begin
            exp_hold = 1'b0;
            if (rpc[0]) begin
                exp_halt = 1'b1;
                exp_err  = 1'b1;
            end else begin
                exp_pc = rpc;
            end
        end else if (exp_hold && !stall_n) begin
            word = mem[exp_pc[6:1]];
            check_eq("acc_instr", instr, word);
            check_eq("acc_pcp2",  pc_plus2, exp_pc + 16'd2);
            acc_cnt++;
            exp_hold = 1'b0;
            exp_pc   = exp_pc + 16'd2;
            if (word[15:11] == OPC_HALT) exp_halt = 1'b1;
        end else if (!exp_hold && !exp_halt && done_n) begin
            exp_hold = 1'b1;
        end

        if (imem_req && !done_n && !eff) cnt++;
        else begin
            cnt     = 0;
            cur_lat = $urandom_range(lat_max, lat_min);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = NOP_INSTR;
        lat_min = 0; lat_max = 0; stall_pct = 0; redir_pct = 0;
        model_reset();

        // Straight-line program ending in HALT, zero-wait memory.
        mem[0] = 16'h4000; mem[1] = 16'h4120; mem[2] = 16'h0000;
        do_reset();
        drive_cycle(1'b0, 1'b0, 16'h0);
        check_eq("first_req", {15'h0, imem_req}, 16'h1);
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 16'h0);
        check_eq("accepts_in_6", 16'(acc_cnt), 16'd3);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 16'h0);
        check_eq("halt_req_low", {15'h0, imem_req}, 16'h0);

        // Decode stalls for 5 cycles on a held word.
        mem[0] = 16'hD8A0; mem[1] = 16'h4120; mem[2] = 16'h0000;
        do_reset();
        drive_cycle(1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b0, 16'h0);
            check_eq("stall_instr", instr, 16'hD8A0);
            check_eq("stall_pcp2",  pc_plus2, 16'h0002);
            check_eq("stall_valid", {15'h0, instr_valid}, 16'h1);
            check_eq("stall_req",   {15'h0, imem_req}, 16'h0);
        end
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b0, 16'h0);

        // Redirect coinciding with imem_done discards the word.
        do_reset();
        drive_cycle(1'b0, 1'b1, 16'h0100);
        drive_cycle(1'b0, 1'b0, 16'h0);
        check_eq("redir_valid", {15'h0, instr_valid}, 16'h0);
        check_eq("redir_req",   {15'h0, imem_req}, 16'h1);
        check_eq("redir_addr",  imem_addr, 16'h0100);

        // Odd redirect target: error, halt, later redirects ignored.
        drive_cycle(1'b0, 1'b1, 16'h0101);
        drive_cycle(1'b0, 1'b1, 16'h0200);
        check_eq("odd_err",    {15'h0, err},    16'h1);
        check_eq("odd_halted", {15'h0, halted}, 16'h1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 16'h0200);
        check_eq("odd_req", {15'h0, imem_req}, 16'h0);

        // PC wraps from 16'hFFFE to 16'h0000.
        mem[63] = 16'h4120;
        do_reset();
        drive_cycle(1'b0, 1'b1, 16'hFFFE);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 16'h0);
        check_eq("wrap_req",  {15'h0, imem_req}, 16'h1);
        check_eq("wrap_addr", imem_addr, 16'h0000);

        // Reset asserted mid-request with 3-cycle memory latency.
        mem[0] = 16'h4000; mem[1] = 16'h4120;
        lat_min = 3; lat_max = 3;
        do_reset();
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b0, 16'h0);
        check_eq("mid_pre_req", {15'h0, imem_req}, 16'h1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_req",   {15'h0, imem_req}, 16'h0);
        check_eq("async_addr",  imem_addr, 16'h0000);
        check_eq("async_instr", instr, NOP_INSTR);
        check_eq("async_pcp2",  pc_plus2, 16'h0000);
        imem_done = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, 1'b0, 16'h0);

        // Random episodes: latency 0..3, random stalls and redirects.
        lat_min = 0; lat_max = 3; stall_pct = 30; redir_pct = 6;
        for (int ep = 0; ep < 20; ep++) begin
            int halt_cycles;
            halt_cycles = 0;
            fill_mem_random();
            do_reset();
            for (int c = 0; c < 200 && halt_cycles < 4; c++) begin
                drive_cycle(1'b0, 1'b0, 16'h0);
                if (exp_halt) halt_cycles++;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
